// File: rtl/mac_conv_sched.sv
// mac_conv_sched: job sequencer and result buffer for a 3x3 dot-product MAC.
// Holds the kernel weights (driven straight out on mac_b), issues one pixel
// window per cycle on mac_a, tracks in-flight MAC results with a valid pipe and
// buffers them in a small FIFO. Issue is credit-limited so the non-stallable
// MAC can never overrun the FIFO.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_wr/cfg_idx/cfg_data    weight write (IDLE only), cfg_err sticky error
//   start, job_len             job launch (IDLE only), number of windows
//   win_valid/win_ready/win_data   window input stream
//   mac_a, mac_b               registered pixel / weight operands to the MAC
//   mac_sum                    MAC total_sum, MAC_LAT cycles after operands
//   res_valid/res_ready/res_data/res_last   result stream (FIFO head)
//   busy, done                 job in progress, one-cycle completion pulse
module mac_conv_sched #(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned NTAPS      = 9,
    parameter int unsigned SUM_W      = 24,
    parameter int unsigned MAC_LAT    = 5,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr,
    input  logic [3:0]              cfg_idx,
    input  logic [DATA_W-1:0]       cfg_data,
    output logic                    cfg_err,
    input  logic                    start,
    input  logic [LEN_W-1:0]        job_len,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [NTAPS*DATA_W-1:0] win_data,
    output logic [NTAPS*DATA_W-1:0] mac_a,
    output logic [NTAPS*DATA_W-1:0] mac_b,
    input  logic [SUM_W-1:0]        mac_sum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [SUM_W-1:0]        res_data,
    output logic                    res_last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PIPE_W = MAC_LAT + 1;
    localparam int unsigned INF_W  = $clog2(PIPE_W + 1);
    localparam int unsigned CRD_W  = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [LEN_W-1:0]      len;
    logic [LEN_W-1:0]      issued;
    logic [LEN_W-1:0]      returned;
    logic [PIPE_W-1:0]     vpipe;
    logic [SUM_W-1:0]      mem_data [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      count_nxt;
    logic [INF_W-1:0]      inflight;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  push_last;

    // Results still inside the MAC (including the one about to be pushed)
    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < PIPE_W; k++) begin
            inflight = inflight + INF_W'(vpipe[k]);
        end
    end

    // Credit rule: a window is only issued if its result is sure to find room
    assign win_ready = (state == RUN) && (issued < len) &&
                       ((CRD_W'(fifo_count) + CRD_W'(inflight)) < CRD_W'(FIFO_DEPTH));
    assign accept    = win_valid && win_ready;
    assign push      = vpipe[MAC_LAT];
    assign pop       = res_valid && res_ready;
    assign push_last = (returned == (len - LEN_W'(1)));
    assign busy      = (state != IDLE);
    assign res_data  = mem_data[rd_ptr];
    assign res_last  = mem_last[rd_ptr];

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = fifo_count - CNT_W'(1);
        end
    end

    // Datapath, FIFO and job FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            issued     <= '0;
            returned   <= '0;
            vpipe      <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            cfg_err    <= 1'b0;
            done       <= 1'b0;
            mem_data   <= '{default: '0};
            mem_last   <= '{default: 1'b0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            res_valid  <= 1'b0;
        end else begin
            done  <= 1'b0;
            vpipe <= {vpipe[PIPE_W-2:0], accept};

            if (accept) begin
                mac_a  <= win_data;
                issued <= issued + LEN_W'(1);
            end

            if (push) begin
                mem_data[wr_ptr] <= mac_sum;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                returned         <= returned + LEN_W'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            fifo_count <= count_nxt;
            res_valid  <= (count_nxt != '0);

            case (state)
                IDLE: begin
                    if (start) begin
                        if (job_len != '0) begin
                            len      <= job_len;
                            issued   <= '0;
                            returned <= '0;
                            cfg_err  <= 1'b0;
                            state    <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    if (cfg_wr) begin
                        if (cfg_idx < IDX_W'(NTAPS)) begin
                            for (int unsigned k = 0; k < NTAPS; k++) begin
                                if (cfg_idx == IDX_W'(k)) begin
                                    mac_b[k*DATA_W +: DATA_W] <= cfg_data;
                                end
                            end
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cfg_wr) begin
                        cfg_err <= 1'b1;
                    end
                    if (accept && (issued == (len - LEN_W'(1)))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cfg_wr) begin
                        cfg_err <= 1'b1;
                    end
                    if (pop && res_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_conv_sched.sv
// tb_mac_conv_sched: directed bench for mac_conv_sched with a 5-stage
// behavioural dot-product MAC attached to mac_a/mac_b/mac_sum.
module tb_mac_conv_sched;

    logic         clk;
    logic         rst_n;
    logic         cfg_wr;
    logic [3:0]   cfg_idx;
    logic [8:0]   cfg_data;
    logic         cfg_err;
    logic         start;
    logic [15:0]  job_len;
    logic         win_valid;
    logic         win_ready;
    logic [80:0]  win_data;
    logic [80:0]  mac_a;
    logic [80:0]  mac_b;
    logic [23:0]  mac_sum;
    logic         res_valid;
    logic         res_ready;
    logic [23:0]  res_data;
    logic         res_last;
    logic         busy;
    logic         done;

    int tests_run    = 0;
    int tests_failed = 0;
    int ovf_events   = 0;

    logic [80:0] win_q [$];
    logic [23:0] exp_q [$];
    logic [80:0] w_ramp;
    logic [80:0] w_rev;
    int          acc_span;
    int          res_span;
    int          acc_hold;
    logic        wr_hold;
    logic        rv_hold;

    mac_conv_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .start     (start),
        .job_len   (job_len),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_sum   (mac_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_last  (res_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: 5 register stages from operands to total_sum
    function automatic logic [23:0] dot9(input logic [80:0] a, input logic [80:0] b);
        logic [23:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) begin
            s = s + 24'(a[k*9 +: 9]) * 24'(b[k*9 +: 9]);
        end
        return s;
    endfunction

    logic [23:0] mac_s [5];
    always @(posedge clk) begin
        mac_s[0] <= dot9(mac_a, mac_b);
        for (int i = 1; i < 5; i++) begin
            mac_s[i] <= mac_s[i-1];
        end
    end
    assign mac_sum = mac_s[4];

    // A push into a full FIFO would silently lose a result
    always @(negedge clk) begin
        if (rst_n && dut.push && (dut.fifo_count == 4'd8)) begin
            ovf_events++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [80:0] uni(input int v);
        logic [80:0] w;
        for (int k = 0; k < 9; k++) begin
            w[k*9 +: 9] = 9'(v);
        end
        return w;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_mac_a"},     128'(mac_a),     128'd0);
        check({tag, "_mac_b"},     128'(mac_b),     128'd0);
        check({tag, "_res_valid"}, 128'(res_valid), 128'd0);
        check({tag, "_res_data"},  128'(res_data),  128'd0);
        check({tag, "_res_last"},  128'(res_last),  128'd0);
        check({tag, "_win_ready"}, 128'(win_ready), 128'd0);
        check({tag, "_busy"},      128'(busy),      128'd0);
        check({tag, "_done"},      128'(done),      128'd0);
        check({tag, "_cfg_err"},   128'(cfg_err),   128'd0);
    endtask

    // Entered and left at a falling edge
    task automatic cfg_write(input logic [3:0] idx, input logic [8:0] val);
        cfg_wr   = 1'b1;
        cfg_idx  = idx;
        cfg_data = val;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] n);
        start   = 1'b1;
        job_len = n;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Feed win_q and collect against exp_q; res_ready held low for 'hold' cycles
    task automatic run_stream(input string tag, input int n, input int hold, input int bound);
        int acc;
        int got;
        int a_first;
        int a_last;
        int r_first;
        int r_last;
        acc = 0; got = 0; a_first = 0; a_last = 0; r_first = 0; r_last = 0;
        res_ready = (hold == 0);
        for (int c = 0; c < bound && got < n; c++) begin
            if (c == hold) begin
                acc_hold  = acc;
                wr_hold   = win_ready;
                rv_hold   = res_valid;
                res_ready = 1'b1;
            end
            if (acc < n) begin
                win_valid = 1'b1;
                win_data  = win_q[acc];
                if (win_ready) begin
                    if (acc == 0) a_first = c;
                    a_last = c;
                    acc++;
                end
            end else begin
                win_valid = 1'b0;
            end
            if (res_valid && res_ready) begin
                check({tag, "_data"}, 128'(res_data), 128'(exp_q[got]));
                check({tag, "_last"}, 128'(res_last), 128'(got == n - 1));
                if (got == 0) r_first = c;
                r_last = c;
                got++;
            end
            @(negedge clk);
        end
        win_valid = 1'b0;
        res_ready = 1'b0;
        acc_span  = a_last - a_first;
        res_span  = r_last - r_first;
        check({tag, "_count"}, 128'(got),  128'(n));
        check({tag, "_done"},  128'(done), 128'd1);
        check({tag, "_idle"},  128'(busy), 128'd0);
    endtask

    initial begin
        int stale;
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_data = '0;
        start = 1'b0; job_len = '0; win_valid = 1'b0; win_data = '0; res_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            w_ramp[k*9 +: 9] = 9'(k);
            w_rev[k*9 +: 9]  = 9'(8 - k);
        end
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Unit weights, single window of 2s: 9*2*1 = 18 after 6 edges
        for (int k = 0; k < 9; k++) cfg_write(4'(k), 9'd1);
        check("t1_mac_b", 128'(mac_b), 128'(uni(1)));
        start_job(16'd1);
        check("t1_busy", 128'(busy), 128'd1);
        check("t1_ready", 128'(win_ready), 128'd1);
        win_valid = 1'b1;
        win_data  = uni(2);
        @(negedge clk);
        win_valid = 1'b0;
        check("t1_mac_a", 128'(mac_a), 128'(uni(2)));
        check("t1_drain_ready", 128'(win_ready), 128'd0);
        repeat (5) @(negedge clk);
        check("t1_not_yet", 128'(res_valid), 128'd0);
        @(negedge clk);
        check("t1_valid", 128'(res_valid), 128'd1);
        check("t1_data", 128'(res_data), 128'd18);
        check("t1_last", 128'(res_last), 128'd1);
        check("t1_no_early_done", 128'(done), 128'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t1_done", 128'(done), 128'd1);
        check("t1_empty", 128'(res_valid), 128'd0);
        @(negedge clk);
        check("t1_done_pulse", 128'(done), 128'd0);
        check("t1_idle", 128'(busy), 128'd0);

        // Ramp weights 0..8, four back-to-back windows
        for (int k = 0; k < 9; k++) cfg_write(4'(k), 9'(k));
        check("t2_mac_b", 128'(mac_b), 128'(w_ramp));
        start_job(16'd4);
        win_q.delete(); exp_q.delete();
        win_q.push_back(uni(1));  exp_q.push_back(24'd36);
        win_q.push_back(w_ramp);  exp_q.push_back(24'd204);
        win_q.push_back(uni(10)); exp_q.push_back(24'd360);
        win_q.push_back(w_rev);   exp_q.push_back(24'd84);
        run_stream("t2", 4, 0, 60);
        check("t2_accept_span", 128'(acc_span), 128'd3);
        check("t2_result_span", 128'(res_span), 128'd3);

        // Back-pressure: 20 windows of value j+1 -> 36*(j+1), only 8 credits
        start_job(16'd20);
        win_q.delete(); exp_q.delete();
        for (int j = 0; j < 20; j++) begin
            win_q.push_back(uni(j + 1));
            exp_q.push_back(24'(36 * (j + 1)));
        end
        run_stream("t3", 20, 30, 300);
        check("t3_accepted_stalled", 128'(acc_hold), 128'd8);
        check("t3_ready_stalled", 128'(wr_hold), 128'd0);
        check("t3_valid_stalled", 128'(rv_hold), 128'd1);

        // Zero-length job
        start_job(16'd0);
        check("t4_done", 128'(done), 128'd1);
        check("t4_busy", 128'(busy), 128'd0);
        @(negedge clk);
        check("t4_done_pulse", 128'(done), 128'd0);
        check("t4_no_result", 128'(res_valid), 128'd0);

        // Illegal weight writes
        cfg_write(4'd12, 9'd7);
        check("t5_err_idx", 128'(cfg_err), 128'd1);
        check("t5_w_idx", 128'(mac_b), 128'(w_ramp));
        start_job(16'd1);
        check("t5_err_clr", 128'(cfg_err), 128'd0);
        cfg_write(4'd0, 9'd100);
        check("t5_err_run", 128'(cfg_err), 128'd1);
        check("t5_w_run", 128'(mac_b), 128'(w_ramp));
        win_q.delete(); exp_q.delete();
        win_q.push_back(uni(1)); exp_q.push_back(24'd36);
        run_stream("t5", 1, 0, 40);
        check("t5_err_held", 128'(cfg_err), 128'd1);

        // Reset with three results in flight
        start_job(16'd5);
        check("t6_err_clr", 128'(cfg_err), 128'd0);
        for (int j = 0; j < 3; j++) begin
            win_valid = 1'b1;
            win_data  = uni(3);
            @(negedge clk);
        end
        win_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (res_valid || busy || win_ready || done) stale++;
        end
        check("t6_stale", 128'(stale), 128'd0);

        // Full-scale operands: 9*511*511
        for (int k = 0; k < 9; k++) cfg_write(4'(k), 9'd511);
        start_job(16'd1);
        win_q.delete(); exp_q.delete();
        win_q.push_back(uni(511)); exp_q.push_back(24'd2350089);
        run_stream("t7", 1, 0, 40);

        check("no_overflow", 128'(ovf_events), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_conv_sched.md
Name: mac_conv_sched

Overview:
- Job sequencer and result buffer for the 3x3 dot-product MAC (9 taps, 9-bit operands, 24-bit sum, fixed 5-stage pipeline, no stall input).
- Holds the 9 kernel weights and accepts a stream of 9-pixel windows on valid/ready.
- Issues at most one window per cycle to the MAC and tracks in-flight results with a valid shift register.
- Buffers results in a FIFO sized for back-pressure. Because the MAC cannot stall, issue is credit-limited so that no result is ever dropped.

Parameters:
- DATA_W, 9, operand width per tap
- NTAPS, 9, taps per window
- SUM_W, 24, MAC result width
- MAC_LAT, 5, number of MAC register stages from operand change to a stable total_sum
- FIFO_DEPTH, 8, result FIFO entries (power of 2, at least 2)
- LEN_W, 16, job length counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  weight write strobe
- cfg_idx  in  4  weight tap index, 0..NTAPS-1
- cfg_data  in  DATA_W  weight value
- cfg_err  out  1  sticky: illegal weight write occurred
- start  in  1  begin job, sampled only in IDLE
- job_len  in  LEN_W  number of windows in the job, latched on start
- win_valid  in  1  window valid
- win_ready  out  1  window accepted when win_valid && win_ready
- win_data  in  NTAPS*DATA_W  window pixels, tap k at bits [k*DATA_W +: DATA_W]
- mac_a  out  NTAPS*DATA_W  registered pixel operands to the MAC
- mac_b  out  NTAPS*DATA_W  registered weight operands to the MAC
- mac_sum  in  SUM_W  MAC total_sum
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  SUM_W  FIFO head
- res_last  out  1  head is the final result of the job
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset state: all outputs 0 (mac_a, mac_b, res_*, win_ready, busy, done, cfg_err). Weights, counters, valid pipe and FIFO cleared. State is IDLE.
- Reset mid-job: aborts the job. In-flight MAC results are discarded. No done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_wr with cfg_idx < NTAPS writes weight[cfg_idx]. mac_b reflects the new weight on the next cycle.
  - cfg_idx >= NTAPS is ignored and sets cfg_err.
  - start with job_len != 0: latch job_len, clear issued/returned counters, clear cfg_err, go to RUN.
  - start with job_len == 0: pulse done next cycle and stay in IDLE.
- RUN:
  - win_ready = (issued < len) && (fifo_count + inflight < FIFO_DEPTH). This is conservative: a same-cycle pop earns no credit.
  - Accept at edge E0: mac_a <= win_data, issued++, and a 1 is shifted into a valid pipe of MAC_LAT+1 bits. Cycles without an accept shift in 0. mac_a holds its value when idle.
  - At edge E0+MAC_LAT+1, mac_sum is pushed into the FIFO, tagged last if it is the len-th result.
  - inflight = popcount(valid pipe).
  - Accepting the len-th window moves the block to DRAIN.
- DRAIN:
  - win_ready = 0.
  - When the last-tagged entry pops (res_valid && res_ready && res_last): done pulses on the next cycle, go to IDLE.
- cfg_wr during RUN or DRAIN: write ignored, cfg_err set. cfg_err is sticky until the next accepted start.
- start outside IDLE is ignored.
- Latency: a window accepted at edge n gives res_valid high after edge n+MAC_LAT+1 (n+6 at defaults), provided the FIFO was empty.
- Throughput: one window per cycle while res_ready is held high.
- FIFO:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - A push is never attempted when full; the credit rule guarantees this and the bench asserts it.
  - res_data and res_last are undefined but stable while res_valid = 0.
- Arithmetic: no arithmetic in this block. mac_sum is passed through unchanged. The worst case 9*511*511 = 2350089 fits SUM_W.

Test Plan:
- Load all weights = 1, job_len = 1, one window of all 2 -> res_valid 6 cycles after accept, res_data = 18, res_last = 1, done pulses the cycle after the pop.
- Weights 0..8, job_len = 4, windows back-to-back with res_ready = 1 -> win_ready stays high, one accept per cycle, 4 consecutive results equal to sum(k*x_k), res_last only on the 4th.
- res_ready = 0, job_len = 20, win_valid held high -> exactly FIFO_DEPTH (8) windows accepted then win_ready = 0. Releasing res_ready yields all 20 results in order with none lost, and no FIFO overflow assertion fires.
- start with job_len = 0 -> done pulses the next cycle, busy stays 0, no res_valid.
- cfg_wr during RUN, and cfg_idx = 12 in IDLE -> weights unchanged, cfg_err = 1 and held, cleared by the next start.
- rst_n low for 1 cycle mid-job with 3 results in flight -> all outputs 0, state IDLE, no stale res_valid after reset release.
- Max operands 511 on all taps and weights -> res_data = 2350089.
